// File: rtl/xvc_pkg.sv
// Shared state encoding and buffer-geometry helpers for the XVC shift engine.
// Default TCK divider lives here so the engine and its phase timer agree.
package xvc_pkg;

  localparam int TCK_DIV_DEFAULT = 4;

  typedef enum logic [3:0] {
    IDLE,
    FETCH_TMS,
    WAIT_TMS,
    FETCH_TDI,
    WAIT_TDI,
    TCK_LOW,
    TCK_HIGH,
    STORE,
    DONE
  } shift_state_t;

  // Largest vector that fits: TMS and TDI halves each get half the buffer.
  function automatic logic [31:0] max_bits(input int addr_w);
    return 32'd8 << (addr_w - 1);
  endfunction

  function automatic logic [31:0] byte_count(input logic [31:0] bits);
    return (bits + 32'd7) >> 3;
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK phase timer: TCK_DIV clocks per half-period, rise/fall strobe on the last clock of
// the low/high phase. No backpressure; runs from start until stop or reset.
module jtag_tck_gen
  import xvc_pkg::*;
#(
  parameter int TCK_DIV = TCK_DIV_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic stop,
  output logic rise,
  output logic fall
);

  localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TCK_DIV - 1);

  logic          active;
  logic          high;
  logic [CW-1:0] cnt;
  logic          term;

  assign term = active && (cnt == LAST);
  assign rise = term && !high;
  assign fall = term && high;

  always_ff @(posedge clock) begin
    if (reset || stop) begin
      active <= 1'b0;
      high   <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      high   <= 1'b0;
      cnt    <= '0;
    end else if (active) begin
      if (term) begin
        cnt  <= '0;
        high <= !high;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/xvc_jtag_shift.sv
// XVC shift engine: plays buffer TMS/TDI onto JTAG, writes TDO back; 5 + 2*TCK_DIV*b clocks per byte,
// start ignored while busy. Define XVC_SHIFT_LOOPBACK_EN to capture TDO from the driven TDI.
module xvc_jtag_shift
  import xvc_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TCK_DIV = TCK_DIV_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       num_bits,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              jtag_tck,
  output logic              jtag_tms,
  output logic              jtag_tdi,
  input  logic              jtag_tdo
);

  localparam int          BW       = ADDR_W + 3;
  localparam logic [31:0] MAX_BITS = max_bits(ADDR_W);

  shift_state_t      state;
  logic [ADDR_W-1:0] nbytes;
  logic [ADDR_W-1:0] byte_idx;
  logic [BW-1:0]     remaining;
  logic [7:0]        tms_byte;
  logic [7:0]        tdi_byte;
  logic [7:0]        tdo_byte;
  logic [2:0]        bit_idx;
  logic [2:0]        next_bit;
  logic [2:0]        last_bit;
  logic              clamp;
  logic [31:0]       bits_eff;
  logic              tdo_src;
  logic              rise;
  logic              fall;
  logic              gen_start;
  logic              gen_stop;

`ifdef XVC_SHIFT_LOOPBACK_EN
  logic unused_tdo;
  assign unused_tdo = jtag_tdo;
  assign tdo_src    = jtag_tdi;
`else
  assign tdo_src = jtag_tdo;
`endif

  assign clamp    = num_bits > MAX_BITS;
  assign bits_eff = clamp ? MAX_BITS : num_bits;
  assign next_bit = bit_idx + 3'd1;
  // Index of the final bit in the current byte; remaining is nonzero while a byte is active.
  assign last_bit = (remaining >= BW'(8)) ? 3'd7 : (remaining[2:0] - 3'd1);

  assign gen_start = (state == WAIT_TDI);
  assign gen_stop  = (state == TCK_HIGH) && fall && (bit_idx == last_bit);

  jtag_tck_gen #(
    .TCK_DIV(TCK_DIV)
  ) u_tck_gen (
    .clock(clock),
    .reset(reset),
    .start(gen_start),
    .stop (gen_stop),
    .rise (rise),
    .fall (fall)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      jtag_tck  <= 1'b0;
      jtag_tms  <= 1'b0;
      jtag_tdi  <= 1'b0;
      nbytes    <= '0;
      byte_idx  <= '0;
      remaining <= '0;
      tms_byte  <= '0;
      tdi_byte  <= '0;
      tdo_byte  <= '0;
      bit_idx   <= '0;
    end else begin
      rd_en <= 1'b0;
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            overflow  <= clamp;
            nbytes    <= ADDR_W'(byte_count(bits_eff));
            remaining <= BW'(bits_eff);
            byte_idx  <= '0;
            if (bits_eff == 32'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= FETCH_TMS;
              rd_en   <= 1'b1;
              rd_addr <= '0;
            end
          end
        end
        FETCH_TMS: state <= WAIT_TMS;
        WAIT_TMS: begin
          tms_byte <= rd_data;
          rd_en    <= 1'b1;
          rd_addr  <= nbytes + byte_idx;
          state    <= FETCH_TDI;
        end
        FETCH_TDI: state <= WAIT_TDI;
        WAIT_TDI: begin
          // First bit goes out straight from the read data as the TDI byte lands.
          tdi_byte <= rd_data;
          tdo_byte <= '0;
          bit_idx  <= '0;
          jtag_tms <= tms_byte[0];
          jtag_tdi <= rd_data[0];
          state    <= TCK_LOW;
        end
        TCK_LOW: begin
          if (rise) begin
            jtag_tck          <= 1'b1;
            tdo_byte[bit_idx] <= tdo_src;
            state             <= TCK_HIGH;
          end
        end
        TCK_HIGH: begin
          if (fall) begin
            jtag_tck <= 1'b0;
            if (bit_idx == last_bit) begin
              wr_en     <= 1'b1;
              wr_addr   <= byte_idx;
              wr_data   <= tdo_byte;
              remaining <= remaining - BW'(last_bit) - BW'(1);
              state     <= STORE;
            end else begin
              bit_idx  <= next_bit;
              jtag_tms <= tms_byte[next_bit];
              jtag_tdi <= tdi_byte[next_bit];
              state    <= TCK_LOW;
            end
          end
        end
        STORE: begin
          if (remaining == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            byte_idx <= byte_idx + ADDR_W'(1);
            rd_en    <= 1'b1;
            rd_addr  <= byte_idx + ADDR_W'(1);
            state    <= FETCH_TMS;
          end
        end
        DONE: begin
          busy     <= 1'b0;
          overflow <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xvc_jtag_shift.sv
// Bench for xvc_jtag_shift: byte-buffer model with 1-cycle read latency, TDO looped to TDI,
// write scoreboard plus per-scenario timing/edge-count checks.
module tb_xvc_jtag_shift;

  localparam int ADDR_W  = 4;
  localparam int TCK_DIV = 1;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [31:0]       num_bits;
  logic              busy, done, overflow;
  logic              rd_en, wr_en;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [7:0]        rd_data, wr_data;
  logic              jtag_tck, jtag_tms, jtag_tdi, jtag_tdo;

  logic [7:0]  mem [0:(1<<ADDR_W)-1];
  logic [11:0] exp_q [$];
  logic        tms_q [$];
  logic [11:0] got_exp;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   e0, done_cyc, done_seen, rd_cnt, wr_cnt, tck_rises, overlap;
  logic ovf_at_done;
  logic tck_prev = 1'b0;

  xvc_jtag_shift #(
    .ADDR_W (ADDR_W),
    .TCK_DIV(TCK_DIV)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .num_bits(num_bits),
    .busy    (busy),
    .done    (done),
    .overflow(overflow),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .jtag_tck(jtag_tck),
    .jtag_tms(jtag_tms),
    .jtag_tdi(jtag_tdi),
    .jtag_tdo(jtag_tdo)
  );

  assign jtag_tdo = jtag_tdi;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // Monitor and write scoreboard, sampled mid-cycle.
  always @(negedge clock) begin
    if (rd_en === 1'b1) rd_cnt++;
    if (rd_en === 1'b1 && wr_en === 1'b1) overlap++;
    if (jtag_tck === 1'b1 && tck_prev === 1'b0) begin
      tck_rises++;
      tms_q.push_back(jtag_tms);
    end
    tck_prev = jtag_tck;
    if (done === 1'b1) begin
      done_seen++;
      done_cyc    = cyc;
      ovf_at_done = overflow;
    end
    if (wr_en === 1'b1) begin
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected: got addr=%0d data=%02h, required no write", wr_addr, wr_data);
      end else begin
        got_exp = exp_q.pop_front();
        if ({wr_addr, wr_data} !== got_exp) begin
          failures++;
          $display("FAIL wr_scoreboard: got addr=%0d data=%02h, required addr=%0d data=%02h",
                   wr_addr, wr_data, got_exp[11:8], got_exp[7:0]);
        end
      end
    end
  end

  function automatic int exp_done(input int bits);
    return 5 * ((bits + 7) / 8) + 2 * TCK_DIV * bits;
  endfunction

  task automatic clear_mon();
    rd_cnt = 0; wr_cnt = 0; tck_rises = 0; done_seen = 0; overlap = 0;
    done_cyc = -1; ovf_at_done = 1'b0;
    tms_q.delete();
  endtask

  // Called #1 after a clock edge with the engine idle; returns #1 after the first IDLE edge.
  task automatic run_shift(input logic [31:0] nb, input int pulse_at, output bit timeout);
    clear_mon();
    num_bits = nb;
    start    = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    e0    = cyc;
    timeout = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (i == pulse_at) begin
        start    = 1'b1;
        num_bits = 32'd16;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        timeout = 1'b0;
        break;
      end
    end
    start = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; num_bits = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({busy, done, overflow, rd_en, wr_en, jtag_tck, jtag_tms, jtag_tdi} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl: got %b, required 00000000",
               {busy, done, overflow, rd_en, wr_en, jtag_tck, jtag_tms, jtag_tdi});
    end
    checks++;
    if ({rd_addr, wr_addr, wr_data} !== 16'h0) begin
      failures++;
      $display("FAIL reset_data: got rd_addr=%0d wr_addr=%0d wr_data=%02h, required all 0",
               rd_addr, wr_addr, wr_data);
    end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_single_byte();
    bit to;
    mem[0] = 8'h00; mem[1] = 8'hA5;
    exp_q.push_back({4'd0, 8'hA5});
    run_shift(32'd8, -1, to);
    checks++;
    if (to) begin failures++; $display("FAIL t1_timeout: got no done, required done pulse"); end
    checks++;
    if (done_cyc - e0 !== exp_done(8)) begin
      failures++; $display("FAIL t1_done_edge: got %0d, required %0d", done_cyc - e0, exp_done(8));
    end
    checks++;
    if (tck_rises !== 8) begin failures++; $display("FAIL t1_tck_rises: got %0d, required 8", tck_rises); end
    checks++;
    if (rd_cnt !== 2) begin failures++; $display("FAIL t1_reads: got %0d, required 2", rd_cnt); end
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL t1_missing_wr: got %0d pending, required 0", exp_q.size()); end
    checks++;
    if ({busy, jtag_tck, jtag_tdi, jtag_tms} !== 4'b0010) begin
      failures++; $display("FAIL t1_idle_lines: got busy/tck/tdi/tms=%b, required 0010", {busy, jtag_tck, jtag_tdi, jtag_tms});
    end
  endtask

  task automatic test_two_bytes();
    bit to;
    mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h34; mem[3] = 8'hFF;
    exp_q.push_back({4'd0, 8'h34});
    exp_q.push_back({4'd1, 8'h0F});
    run_shift(32'd12, -1, to);
    checks++;
    if (to) begin failures++; $display("FAIL t2_timeout: got no done, required done pulse"); end
    checks++;
    if (done_cyc - e0 !== exp_done(12)) begin
      failures++; $display("FAIL t2_done_edge: got %0d, required %0d", done_cyc - e0, exp_done(12));
    end
    checks++;
    if (tck_rises !== 12) begin failures++; $display("FAIL t2_tck_rises: got %0d, required 12", tck_rises); end
    checks++;
    if (rd_cnt !== 4 || overlap !== 0) begin
      failures++; $display("FAIL t2_reads: got reads=%0d overlap=%0d, required 4 and 0", rd_cnt, overlap);
    end
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL t2_missing_wr: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_tms_pattern();
    bit to;
    logic [7:0] tms_exp;
    tms_exp = 8'h1F;
    mem[0] = 8'h1F; mem[1] = 8'hC3;
    exp_q.push_back({4'd0, 8'hC3});
    run_shift(32'd8, -1, to);
    checks++;
    if (to || tck_rises !== 8) begin
      failures++; $display("FAIL t3_rises: got timeout=%0d rises=%0d, required 0 and 8", to, tck_rises);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (tms_q.size() <= k || tms_q[k] !== tms_exp[k]) begin
        failures++; $display("FAIL t3_tms_rise%0d: got %b, required %b", k, (tms_q.size() > k) ? tms_q[k] : 1'bx, tms_exp[k]);
      end
    end
  endtask

  task automatic test_zero_bits();
    bit to;
    run_shift(32'd0, -1, to);
    checks++;
    if (to || done_seen !== 1) begin
      failures++; $display("FAIL t4_done: got timeout=%0d pulses=%0d, required 0 and 1", to, done_seen);
    end
    checks++;
    if (done_cyc - e0 !== 0) begin failures++; $display("FAIL t4_done_edge: got %0d, required 0", done_cyc - e0); end
    checks++;
    if (rd_cnt !== 0 || wr_cnt !== 0 || tck_rises !== 0) begin
      failures++; $display("FAIL t4_activity: got reads=%0d writes=%0d rises=%0d, required 0 0 0", rd_cnt, wr_cnt, tck_rises);
    end
  endtask

  task automatic test_clamp();
    bit to;
    int nbs [3];
    nbs = '{64, 100, 65};
    foreach (nbs[j]) begin
      for (int a = 0; a < 16; a++) mem[a] = 8'($urandom);
      for (int i = 0; i < 8; i++) exp_q.push_back({4'(i), mem[8+i]});
      run_shift(32'(nbs[j]), -1, to);
      checks++;
      if (to) begin failures++; $display("FAIL t5_timeout_%0d: got no done, required done pulse", nbs[j]); end
      checks++;
      if (ovf_at_done !== (nbs[j] > 64)) begin
        failures++; $display("FAIL t5_overflow_%0d: got %b, required %b", nbs[j], ovf_at_done, nbs[j] > 64);
      end
      checks++;
      if (tck_rises !== 64 || wr_cnt !== 8) begin
        failures++; $display("FAIL t5_size_%0d: got rises=%0d writes=%0d, required 64 and 8", nbs[j], tck_rises, wr_cnt);
      end
      checks++;
      if (done_cyc - e0 !== exp_done(64)) begin
        failures++; $display("FAIL t5_done_edge_%0d: got %0d, required %0d", nbs[j], done_cyc - e0, exp_done(64));
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    mem[0] = 8'h00; mem[1] = 8'h96;
    exp_q.push_back({4'd0, 8'h96});
    run_shift(32'd8, 2, to);
    checks++;
    if (to || done_cyc - e0 !== exp_done(8) || done_seen !== 1 || wr_cnt !== 1) begin
      failures++;
      $display("FAIL bb_ignore_start: got timeout=%0d edge=%0d pulses=%0d writes=%0d, required 0 %0d 1 1",
               to, done_cyc - e0, done_seen, wr_cnt, exp_done(8));
    end
    mem[1] = 8'h3C;
    exp_q.push_back({4'd0, 8'h3C});
    run_shift(32'd8, -1, to);
    checks++;
    if (to || done_cyc - e0 !== exp_done(8)) begin
      failures++; $display("FAIL bb_restart: got timeout=%0d edge=%0d, required 0 %0d", to, done_cyc - e0, exp_done(8));
    end
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL bb_missing_wr: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit   hit;
    logic last_tck;
    int   r;
    hit = 1'b0; last_tck = 1'b0; r = 0;
    mem[0] = 8'h00; mem[1] = 8'h5A;
    clear_mon();
    num_bits = 32'd8;
    start    = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      start = (i == 1);
      if (jtag_tck === 1'b1 && last_tck === 1'b0) r++;
      last_tck = jtag_tck;
      if (r == 4 && jtag_tck === 1'b1) begin
        hit = 1'b1;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (!hit) begin failures++; $display("FAIL t6_reach_bit3: got %0d rises, required TCK high of bit 3", r); end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({busy, done, overflow, rd_en, wr_en, jtag_tck, jtag_tms, jtag_tdi, rd_addr, wr_addr, wr_data} !== 24'h0) begin
      failures++;
      $display("FAIL t6_reset_outputs: got %h, required 000000",
               {busy, done, overflow, rd_en, wr_en, jtag_tck, jtag_tms, jtag_tdi, rd_addr, wr_addr, wr_data});
    end
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (40) @(posedge clock);
    #1;
    checks++;
    if (wr_cnt !== 0 || done_seen !== 0) begin
      failures++; $display("FAIL t6_no_finish: got writes=%0d done=%0d, required 0 0", wr_cnt, done_seen);
    end
    checks++;
    if (busy !== 1'b0 || rd_cnt !== 2) begin
      failures++; $display("FAIL t6_idle_after: got busy=%b reads=%0d, required 0 and 2", busy, rd_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_two_bytes();
    test_tms_pattern();
    test_zero_bits();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

endmodule
